// File: rtl/mips32_fetch_queue.sv
// rtl/mips32_fetch_queue.sv - instruction prefetch queue between instruction memory and the IF/ID stage
// Optional feature macro HLT_STOP_EN: stop issuing fetches once an HLT opcode has been queued.
module mips32_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [31:0]       resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall_fetch,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_ir,
  output logic [31:0]       if_npc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     tag_rd_q, tag_rd_d;
  logic [PW-1:0]     tag_wr_q, tag_wr_d;
  logic [31:0]       ir_mem_q  [DEPTH];
  logic [31:0]       ir_mem_d  [DEPTH];
  logic [ADDR_W-1:0] npc_mem_q [DEPTH];
  logic [ADDR_W-1:0] npc_mem_d [DEPTH];
  logic [ADDR_W-1:0] tag_mem_q [DEPTH];
  logic [ADDR_W-1:0] tag_mem_d [DEPTH];

  logic credit_ok;
  logic req_fire;
  logic push;
  logic drop;
  logic pop;
  logic stopped;

`ifdef HLT_STOP_EN
  logic stopped_q, stopped_d;
  assign stopped = stopped_q;
`else
  assign stopped = 1'b0;
`endif

  // Buffered entries plus in-flight requests never exceed DEPTH, so a push always has room.
  assign credit_ok = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C;
  assign req_valid = rst_n && !redirect_valid && !stall_fetch && !stopped && credit_ok;
  assign req_addr  = fetch_pc_q;
  assign req_fire  = req_valid && req_ready;

  assign if_valid  = (count_q != '0);
  assign if_ir     = ir_mem_q[rd_ptr_q];
  assign if_npc    = {{(32-ADDR_W){1'b0}}, npc_mem_q[rd_ptr_q]};

  assign push = resp_valid && (discard_q == '0);
  assign drop = resp_valid && (discard_q != '0);
  assign pop  = if_valid && if_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;
    ir_mem_d      = ir_mem_q;
    npc_mem_d     = npc_mem_q;
    tag_mem_d     = tag_mem_q;
`ifdef HLT_STOP_EN
    stopped_d     = stopped_q;
`endif
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_valid);

    // The tag FIFO mirrors the memory's in-order request queue, dropped responses included.
    if (resp_valid) begin
      tag_rd_d = tag_rd_q + 1'b1;
    end
    if (req_fire) begin
      tag_mem_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d            = tag_wr_q + 1'b1;
      fetch_pc_d          = fetch_pc_q + 1'b1;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      discard_d  = outstanding_q - CW'(resp_valid);
`ifdef HLT_STOP_EN
      stopped_d  = 1'b0;
`endif
    end else begin
      if (drop) begin
        discard_d = discard_q - 1'b1;
      end
      if (push) begin
        ir_mem_d[wr_ptr_q]  = resp_data;
        npc_mem_d[wr_ptr_q] = tag_mem_q[tag_rd_q] + 1'b1;
        wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
`ifdef HLT_STOP_EN
      if (push && (resp_data[31:26] == 6'b111111)) begin
        stopped_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= ADDR_W'(RESET_PC);
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i]  <= '0;
        npc_mem_q[i] <= '0;
        tag_mem_q[i] <= '0;
      end
`ifdef HLT_STOP_EN
      stopped_q     <= 1'b0;
`endif
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
      ir_mem_q      <= ir_mem_d;
      npc_mem_q     <= npc_mem_d;
      tag_mem_q     <= tag_mem_d;
`ifdef HLT_STOP_EN
      stopped_q     <= stopped_d;
`endif
    end
  end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// tb/tb_mips32_fetch_queue.sv - directed bench with a queue-level reference model for mips32_fetch_queue
module tb_mips32_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int AMOD   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid;
  logic              req_ready = 1'b1;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid = 1'b0;
  logic [31:0]       resp_data = 32'h0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              stall_fetch = 1'b0;
  logic              if_valid;
  logic              if_ready = 1'b1;
  logic [31:0]       if_ir;
  logic [31:0]       if_npc;

  mips32_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_fetch(stall_fetch),
    .if_valid(if_valid), .if_ready(if_ready), .if_ir(if_ir), .if_npc(if_npc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat = 1;
  int hlt_addr = -1;
  int accepts = 0;

  typedef struct { int addr; int ready; } mreq_t;
  typedef struct { int addr; bit live; } flight_t;
  typedef struct { logic [31:0] ir; logic [31:0] npc; } ent_t;

  mreq_t   mq[$];
  flight_t fl[$];
  ent_t    mdl[$];
  int      m_pc = 0;
  bit      m_stopped = 1'b0;

  function automatic logic [31:0] memfun(int a);
    if (a == hlt_addr) return 32'hFC00_0000;
    return 32'h1000_0000 + 32'(a * 3);
  endfunction

  function automatic bit mem_pending();
    return (mq.size() != 0) && (mq[0].ready <= cyc);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder plus per-cycle comparison against the model.
  always begin
    bit          exp_rv, m_fire, d_fire;
    logic [ADDR_W-1:0] d_addr;
    flight_t     h;
    ent_t        e;
    bit          have;
    @(negedge clk);
    #1;
    resp_valid = rst_n && mem_pending();
    resp_data  = resp_valid ? memfun(mq[0].addr) : 32'h0;
    #1;
    exp_rv = rst_n && !redirect_valid && !stall_fetch && !m_stopped &&
             ((mdl.size() + fl.size()) < DEPTH);
    chk("req_valid", req_valid, exp_rv);
    chk("req_addr", req_addr, 32'(m_pc));
    chk("if_valid", if_valid, mdl.size() != 0);
    if (mdl.size() != 0) begin
      chk("if_ir", if_ir, mdl[0].ir);
      chk("if_npc", if_npc, mdl[0].npc);
    end
    d_fire = req_valid && req_ready;
    d_addr = req_addr;
    m_fire = exp_rv && req_ready;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      fl.delete();
      mdl.delete();
      m_pc = 0;
      m_stopped = 1'b0;
    end else begin
      if (resp_valid) void'(mq.pop_front());
      if (d_fire) begin
        mq.push_back('{int'(d_addr), cyc + lat});
        accepts++;
      end
      have = 1'b0;
      if (resp_valid && fl.size() != 0) begin
        h = fl.pop_front();
        if (h.live && !redirect_valid) begin
          have  = 1'b1;
          e.ir  = memfun(h.addr);
          e.npc = 32'((h.addr + 1) % AMOD);
        end
      end
      if (redirect_valid) begin
        mdl.delete();
        foreach (fl[i]) fl[i].live = 1'b0;
        m_pc = int'(redirect_pc);
        m_stopped = 1'b0;
      end else begin
        if (mdl.size() != 0 && if_ready) void'(mdl.pop_front());
        if (have) begin
          mdl.push_back(e);
`ifdef HLT_STOP_EN
          if (e.ir[31:26] == 6'b111111) m_stopped = 1'b1;
`endif
        end
        if (m_fire) begin
          fl.push_back('{m_pc, 1'b1});
          m_pc = (m_pc + 1) % AMOD;
        end
      end
    end
    cyc++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    stall_fetch = 1'b0;
    accepts = 0;
    repeat (2) @(negedge clk);
    accepts = 0;
  endtask

  initial begin
    int n;
    // Streaming fetch with 1-cycle memory
    lat = 1; if_ready = 1'b1; req_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("t1_rst_req_valid", req_valid, 1);
    chk("t1_rst_req_addr", req_addr, 0);
    chk("t1_rst_if_valid", if_valid, 0);
    chk("t1_rst_if_ir", if_ir, 0);
    chk("t1_rst_if_npc", if_npc, 0);
    repeat (2) @(negedge clk);
    #3;
    chk("t1_first_ir", if_ir, 32'h1000_0000);
    chk("t1_first_npc", if_npc, 1);
    repeat (10) @(negedge clk);

    // Back-pressure fills the queue with exactly DEPTH requests
    do_reset();
    if_ready = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    chk("t2_accepts", accepts, 4);
    chk("t2_req_blocked", req_valid, 0);
    chk("t2_head_ir", if_ir, 32'h1000_0000);
    @(negedge clk);
    if_ready = 1'b1;
    #3;
    chk("t2_head_npc", if_npc, 1);
    @(negedge clk);
    #3;
    chk("t2_resume_valid", req_valid, 1);
    chk("t2_resume_addr", req_addr, 4);
    chk("t2_next_npc", if_npc, 2);
    repeat (12) @(negedge clk);

    // Redirect with three long-latency responses in flight
    do_reset();
    lat = 5;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 10'h020;
    #3;
    chk("t3_redir_no_req", req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    n = 0;
    while (!if_valid && n < 30) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("t3_wait_bound", n < 30, 1);
    chk("t3_target_ir", if_ir, 32'h1000_0060);
    chk("t3_target_npc", if_npc, 32'h21);
    repeat (10) @(negedge clk);

    // Address wrap at the top of the word space
    do_reset();
    lat = 1;
    rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'h3FF;
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    chk("t4_addr_top", req_addr, 32'h3FF);
    @(negedge clk);
    #3;
    chk("t4_addr_wrap", req_addr, 0);
    @(negedge clk);
    #3;
    chk("t4_top_ir", if_ir, 32'h1000_0BFD);
    chk("t4_top_npc", if_npc, 0);
    repeat (6) @(negedge clk);

    // Redirect coinciding with a response and a pop
    do_reset();
    lat = 3;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n = 0;
    while (!mem_pending() && n < 10) begin
      @(negedge clk);
      n++;
    end
    redirect_valid = 1'b1;
    redirect_pc = 10'h040;
    #3;
    chk("t5_resp_same_cycle", resp_valid, 1);
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    chk("t5_flushed", if_valid, 0);
    n = 0;
    while (!if_valid && n < 30) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("t5_wait_bound", n < 30, 1);
    chk("t5_target_ir", if_ir, 32'h1000_00C0);
    chk("t5_target_npc", if_npc, 32'h41);
    repeat (6) @(negedge clk);

    // stall_fetch blocks requests while the queue keeps draining
    stall_fetch = 1'b1;
    #3;
    chk("t6_stall_req", req_valid, 0);
    repeat (8) @(negedge clk);
    #3;
    chk("t6_drained", if_valid, 0);
    @(negedge clk);
    stall_fetch = 1'b0;
    repeat (6) @(negedge clk);

    // HLT at word 2
    do_reset();
    lat = 1;
    hlt_addr = 2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk("t7_hlt_ir", if_ir, 32'hFC00_0000);
    chk("t7_hlt_npc", if_npc, 3);
    repeat (6) @(negedge clk);
    #3;
`ifdef HLT_STOP_EN
    chk("t7_stopped_accepts", accepts, 4);
    chk("t7_stopped_req", req_valid, 0);
`else
    chk("t7_no_stop_req", req_valid, 1);
`endif
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 10'h010;
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    chk("t7_resume_valid", req_valid, 1);
    chk("t7_resume_addr", req_addr, 32'h10);
    repeat (8) @(negedge clk);
    hlt_addr = -1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
